// File: rtl/std_cache_pkg.sv
// Shared cache scheduler types and default geometry constants.
package std_cache_pkg;
  typedef enum logic {INIT, RUN} sched_state_e;

  localparam int DEF_BYTE_OFFSET = 4;
  localparam int DEF_INDEX_WIDTH = 12;
endpackage

// File: rtl/dcache_rr_arb.sv
// Round-robin arbiter: masked priority encoder starting at a pointer that
// cycles over ports 1..NR_PORTS-1. The caller must drive req_i[0] low.
module dcache_rr_arb #(
  parameter int NR_PORTS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NR_PORTS-1:0] req_i,
  input  logic                upd_i,
  output logic [NR_PORTS-1:0] gnt_o
);
  localparam int PW = (NR_PORTS > 2) ? $clog2(NR_PORTS) : 1;

  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       w_win;
  logic                w_hit;
  logic [NR_PORTS-1:0] w_mask, w_masked, w_sel;

  always_comb begin
    for (int i = 0; i < NR_PORTS; i++) w_mask[i] = (PW'(i) >= r_ptr);
    w_masked = req_i & w_mask;
    // nothing at or above the pointer: wrap to the lowest requester
    w_sel = (|w_masked) ? w_masked : req_i;
    w_win = '0;
    w_hit = 1'b0;
    for (int i = NR_PORTS-1; i >= 0; i--) begin
      if (w_sel[i]) begin
        w_win = PW'(i);
        w_hit = 1'b1;
      end
    end
    gnt_o = '0;
    if (w_hit) gnt_o[w_win] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= PW'(1);
    end else if (upd_i && w_hit) begin
      r_ptr <= (w_win == PW'(NR_PORTS-1)) ? PW'(1) : w_win + PW'(1);
    end
  end
endmodule

// File: rtl/dcache_sram_sched.sv
// D-cache SRAM port scheduler: clears the array after reset/invalidate, then
// grants one requester per cycle (port 0 first). Define DCACHE_SCHED_RR_EN for
// round-robin among ports 1..NR_PORTS-1, otherwise fixed lowest-index priority.
module dcache_sram_sched
  import std_cache_pkg::*;
#(
  parameter int NR_PORTS    = 4,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int BYTE_OFFSET = DEF_BYTE_OFFSET,
  parameter int DATA_WIDTH  = 128
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  invalidate_i,
  input  logic [NR_PORTS-1:0]                   req_i,
  input  logic [NR_PORTS-1:0][INDEX_WIDTH-1:0]  addr_i,
  input  logic [NR_PORTS-1:0]                   we_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
  output logic [NR_PORTS-1:0]                   gnt_o,
  output logic [NR_PORTS-1:0]                   rvalid_o,
  output logic                                  ram_req_o,
  output logic [INDEX_WIDTH-BYTE_OFFSET-1:0]    ram_addr_o,
  output logic                                  ram_we_o,
  output logic [DATA_WIDTH-1:0]                 ram_wdata_o,
  output logic                                  init_done_o
);
  localparam int LW        = INDEX_WIDTH - BYTE_OFFSET;
  localparam int NUM_LINES = 2**LW;

  sched_state_e        r_state;
  logic [LW:0]         r_idx;
  logic [NR_PORTS-1:0] r_rvalid;
  logic [NR_PORTS-1:0] w_gnt, w_sub_gnt;
  logic                w_run;
  logic                w_unused;

  assign w_run = (r_state == RUN) && !rst_i;

`ifdef DCACHE_SCHED_RR_EN
  logic [NR_PORTS-1:0] w_sub_req;
  assign w_sub_req = {req_i[NR_PORTS-1:1], 1'b0};

  dcache_rr_arb #(.NR_PORTS(NR_PORTS)) u_rr_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (w_sub_req),
    .upd_i (w_run && !req_i[0]),
    .gnt_o (w_sub_gnt)
  );
`else
  always_comb begin
    w_sub_gnt = '0;
    for (int i = NR_PORTS-1; i >= 1; i--) begin
      if (req_i[i]) begin
        w_sub_gnt    = '0;
        w_sub_gnt[i] = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_gnt = '0;
    if (w_run) begin
      if (req_i[0]) w_gnt[0] = 1'b1;
      else          w_gnt    = w_sub_gnt;
    end
  end

  always_comb begin
    ram_req_o   = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_wdata_o = '0;
    if (!rst_i) begin
      if (r_state == INIT) begin
        ram_req_o  = 1'b1;
        ram_we_o   = 1'b1;
        ram_addr_o = r_idx[LW-1:0];
      end else begin
        for (int w = 0; w < NR_PORTS; w++) begin
          if (w_gnt[w]) begin
            ram_req_o   = 1'b1;
            ram_addr_o  = addr_i[w][INDEX_WIDTH-1:BYTE_OFFSET];
            ram_we_o    = we_i[w];
            ram_wdata_o = wdata_i[w];
          end
        end
      end
    end
  end

  // byte-within-line bits never reach the line-addressed SRAM
  always_comb begin
    w_unused = 1'b0;
    for (int w = 0; w < NR_PORTS; w++) w_unused = w_unused ^ (^addr_i[w][BYTE_OFFSET-1:0]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= INIT;
      r_idx    <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= w_gnt & ~we_i;
      case (r_state)
        INIT: begin
          if (invalidate_i) begin
            r_idx <= '0;
          end else if (r_idx == (LW+1)'(NUM_LINES-1)) begin
            r_state <= RUN;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          if (invalidate_i) begin
            r_state <= INIT;
            r_idx   <= '0;
          end
        end
      endcase
    end
  end

  assign gnt_o       = w_gnt;
  assign rvalid_o    = r_rvalid & {NR_PORTS{!rst_i}};
  assign init_done_o = w_run;
endmodule

// File: tb/tb_dcache_sram_sched.sv
// Scoreboard bench for dcache_sram_sched against a cycle-level reference model.
module tb_dcache_sram_sched;
  localparam int NR = 4;
  localparam int IW = 12;
  localparam int BO = 4;
  localparam int DW = 128;
  localparam int LW = IW - BO;
  localparam int NL = 2**LW;

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [LW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } ram_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1, invalidate_i = 1'b0;
  logic [NR-1:0] req_i = '0, we_i = '0;
  logic [NR-1:0][IW-1:0] addr_i = '0;
  logic [NR-1:0][DW-1:0] wdata_i = '0;
  logic [NR-1:0] gnt_o, rvalid_o;
  logic ram_req_o, ram_we_o, init_done_o;
  logic [LW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;

  dcache_sram_sched #(.NR_PORTS(NR), .INDEX_WIDTH(IW), .BYTE_OFFSET(BO), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .invalidate_i(invalidate_i), .req_i(req_i), .addr_i(addr_i),
    .we_i(we_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .ram_req_o(ram_req_o),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o), .init_done_o(init_done_o)
  );

  always #5 clk = ~clk;

  ram_t          q_ram[$];
  logic [NR-1:0] q_rv[$];
  logic          q_st[$];
  int n_chk = 0, n_pass = 0;
  bit started = 0;

  // reference model state
  bit            m_run = 0;
  int            m_idx = 0;
  int            m_ptr = 1;
  logic [NR-1:0] m_pend = '0;

  function automatic logic [NR-1:0][IW-1:0] rnd_addr();
    logic [NR-1:0][IW-1:0] a;
    for (int i = 0; i < NR; i++) a[i] = IW'($urandom);
    return a;
  endfunction

  function automatic logic [NR-1:0][DW-1:0] rnd_data();
    logic [NR-1:0][DW-1:0] d;
    for (int i = 0; i < NR; i++) d[i] = {$urandom, $urandom, $urandom, $urandom};
    return d;
  endfunction

  task automatic step(input logic rst, input logic inv, input logic [NR-1:0] req,
                      input logic [NR-1:0] we, input logic [NR-1:0][IW-1:0] a,
                      input logic [NR-1:0][DW-1:0] d);
    ram_t e;
    int w;
    @(posedge clk);
    #1;
    rst_i = rst; invalidate_i = inv; req_i = req; we_i = we; addr_i = a; wdata_i = d;
    started = 1;
    if (rst) begin
      q_st.push_back(1'b0);
      m_run = 0; m_idx = 0; m_ptr = 1; m_pend = '0;
    end else begin
      q_st.push_back(m_run);
      if (m_pend != '0) q_rv.push_back(m_pend);
      m_pend = '0;
      if (!m_run) begin
        e.gnt = '0; e.addr = LW'(m_idx); e.we = 1'b1; e.wdata = '0;
        q_ram.push_back(e);
        if (inv) m_idx = 0;
        else if (m_idx == NL-1) begin m_run = 1; m_idx = 0; end
        else m_idx++;
      end else begin
        w = -1;
        if (req[0]) w = 0;
        else begin
`ifdef DCACHE_SCHED_RR_EN
          for (int k = 0; k < NR-1; k++) begin
            int p;
            p = ((m_ptr - 1 + k) % (NR-1)) + 1;
            if (w < 0 && req[p]) w = p;
          end
`else
          for (int p = NR-1; p >= 1; p--) if (req[p]) w = p;
`endif
        end
        if (w >= 0) begin
          e.gnt = '0; e.gnt[w] = 1'b1;
          e.addr = a[w][IW-1:BO]; e.we = we[w]; e.wdata = d[w];
          q_ram.push_back(e);
          if (!we[w]) m_pend[w] = 1'b1;
          if (w >= 1) m_ptr = (w == NR-1) ? 1 : w + 1;
        end
        if (inv) begin m_run = 0; m_idx = 0; end
      end
    end
  endtask

  task automatic rstep(input logic rst, input logic inv);
    step(rst, inv, NR'($urandom), NR'($urandom), rnd_addr(), rnd_data());
  endtask

  // monitor: compares whatever the DUT presents against the scoreboard queues
  ram_t g_ram, x_ram;
  logic [NR-1:0] x_rv;
  logic x_st;
  always @(negedge clk) begin
    if (started) begin
      n_chk++;
      if (q_st.size() == 0) $display("FAIL init_done: no expectation queued, got %b", init_done_o);
      else begin
        x_st = q_st.pop_front();
        if (init_done_o === x_st) n_pass++;
        else $display("FAIL init_done: got %b want %b", init_done_o, x_st);
      end
      if (ram_req_o !== 1'b0 || gnt_o !== '0) begin
        g_ram = '{gnt: gnt_o, addr: ram_addr_o, we: ram_we_o, wdata: ram_wdata_o};
        n_chk++;
        if (ram_req_o !== 1'b1 || q_ram.size() == 0)
          $display("FAIL ram: unexpected access req=%b gnt=%b addr=%h we=%b", ram_req_o, gnt_o, ram_addr_o, ram_we_o);
        else begin
          x_ram = q_ram.pop_front();
          if (g_ram === x_ram) n_pass++;
          else $display("FAIL ram: got gnt=%b addr=%h we=%b wd=%h want gnt=%b addr=%h we=%b wd=%h",
                        g_ram.gnt, g_ram.addr, g_ram.we, g_ram.wdata, x_ram.gnt, x_ram.addr, x_ram.we, x_ram.wdata);
        end
      end
      if (rvalid_o !== '0) begin
        n_chk++;
        if (q_rv.size() == 0) $display("FAIL rvalid: got %b want none", rvalid_o);
        else begin
          x_rv = q_rv.pop_front();
          if (rvalid_o === x_rv) n_pass++;
          else $display("FAIL rvalid: got %b want %b", rvalid_o, x_rv);
        end
      end
    end
  end

  initial begin
    logic [NR-1:0][IW-1:0] a;
    logic [NR-1:0][DW-1:0] d;
    repeat (3) rstep(1'b1, 1'b0);
    // full sweep with requests that must be ignored
    repeat (NL) rstep(1'b0, 1'b0);
    // port 0 always wins, reads answered next cycle
    repeat (4) step(1'b0, 1'b0, 4'b1111, 4'b0000, rnd_addr(), rnd_data());
    repeat (6) step(1'b0, 1'b0, 4'b1110, 4'b0000, rnd_addr(), rnd_data());
    a = rnd_addr(); d = rnd_data();
    a[2] = 12'h3A0; d[2] = 128'hAB;
    step(1'b0, 1'b0, 4'b0100, 4'b0100, a, d);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, a, d);
    // invalidate during a port 1 read grant
    step(1'b0, 1'b1, 4'b0010, 4'b0000, rnd_addr(), rnd_data());
    repeat (50) rstep(1'b0, 1'b0);
    rstep(1'b0, 1'b1);
    repeat (30) rstep(1'b0, 1'b0);
    rstep(1'b1, 1'b0);
    repeat (NL + 20) rstep(1'b0, 1'b0);
    // randomized traffic with rare invalidates and resets
    repeat (3000) rstep(($urandom % 500) == 0, ($urandom % 300) == 0);
    repeat (2) step(1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    #1;
    n_chk++;
    if (q_ram.size() == 0 && q_rv.size() == 0) n_pass++;
    else $display("FAIL drain: ram left %0d rvalid left %0d want 0 0", q_ram.size(), q_rv.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
